mm_tile_controller: RTL
=======================

# mm_tile_controller

Parametrised N×N integer matrix-multiply tile engine: C = A·B (+ previous C) over a runtime-selectable inner dimension K. It fetches operands from a single-port BRAM, accumulates in an internal N×N MAC array, and writes C back to the same BRAM. It is the successor of the fixed 8×8 single-pass PE controller: N, element width, read latency and base addresses are configurable, and an accumulate mode supports K-tiling across starts.

## Interface
- LINE_SIZE, 8: tile edge N; N×N accumulators; 2 ≤ N ≤ 16.
- DATA_WIDTH, 8: signed operand width, taken from bits [DATA_WIDTH-1:0] of each BRAM word.
- ACC_WIDTH, 32: accumulator width; ≤ BRAM_DATA_WIDTH.
- BRAM_ADDR_WIDTH, 15: byte address width.
- BRAM_DATA_WIDTH, 32: BRAM word width; BYTES = BRAM_DATA_WIDTH/8.
- K_WIDTH, 8: width of k_len.
- RD_LAT, 1: BRAM read latency in cycles, 1..3.
- DONE_STATE_CYCLE, 5: cycles done stays high.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  launch; sampled only in IDLE.
- k_len  in  K_WIDTH  inner dimension K; sampled with start.
- acc_en  in  1  1: keep accumulators from previous run; 0: clear at start.
- a_base, b_base, c_base  in  BRAM_ADDR_WIDTH each  byte base addresses; sampled with start.
- bram_addr  out  BRAM_ADDR_WIDTH  registered address.
- bram_rddata  in  BRAM_DATA_WIDTH  read data, valid RD_LAT cycles after the address.
- bram_wrdata  out  BRAM_DATA_WIDTH  write data.
- bram_we  out  BYTES  byte write enables, all-ones or zero.
- busy  out  1  high in every state except IDLE.
- done  out  1  completion flag.

## Operation
- Layouts are row-major. A[i][k] is at a_base+(i·K+k)·BYTES. B[k][j] is at b_base+(k·N+j)·BYTES. C[i][j] is at c_base+(i·N+j)·BYTES. All address arithmetic wraps modulo 2^BRAM_ADDR_WIDTH.
- States: IDLE, LOADA, LOADB, DRAIN, MAC, WRITE, DONE.
- IDLE: on start, latch k_len, bases and acc_en. If acc_en=0, clear all accumulators. Set k=0. Go to LOADA, or to WRITE if k_len=0.
- LOADA: issue N reads, one per cycle, for A[0..N-1][k]. Read data is captured into abuf[i] RD_LAT cycles after issue, via a tag shift register.
- LOADB: issue N reads, one per cycle, for B[k][0..N-1] into bbuf[j].
- DRAIN: hold for RD_LAT cycles until the last datum is captured.
- MAC: for all i,j in one cycle, acc[i][j] += sext(abuf[i])·sext(bbuf[j]). The result is truncated modulo 2^ACC_WIDTH (wrap, no saturation). Then k++; go to LOADA if k<K, else WRITE.
- WRITE: N·N cycles, row-major. Each cycle drives bram_addr=C address, bram_wrdata=sext(acc[i][j]) and bram_we=all-ones. After the last write, bram_we=0 and go to DONE.
- DONE: done=1 for exactly DONE_STATE_CYCLE cycles, then IDLE.
- Accumulators hold their values through IDLE, so a following start with acc_en=1 continues the sum.
- A start pulse outside IDLE is ignored; k_len, the bases and acc_en are not re-sampled.
- bram_we=0 in every state except WRITE.

## Timing
- Reset values: bram_addr=0, bram_wrdata=0, bram_we=0, done=0, busy=0, state=IDLE. Accumulators, abuf/bbuf and all counters are cleared.
- Reset asserted mid-operation aborts immediately; the write in flight is dropped by bram_we=0. Normal operation restarts on the first edge after release.
- Let e0 be the edge that samples start. bram_addr shows A[0][0]'s address in the cycle after e0.
- Each k step takes 2N+RD_LAT+1 cycles.
- The first write cycle is K·(2N+RD_LAT+1) cycles after e0. done rises K·(2N+RD_LAT+1)+N² cycles after e0.
- busy rises the cycle after e0. busy falls together with done.
- With k_len=0, WRITE starts the cycle after e0. It writes zeros (acc_en=0) or the held accumulators (acc_en=1).

## Test plan
- N=4, RD_LAT=1, K=4, acc_en=0, A=identity, B[k][j]=4k+j: C equals B. done rises 56 cycles after e0 and stays high 5 cycles.
- N=4, K=2, A=all 2, B=all 3: C=12 everywhere. Restart with acc_en=1 on the same data: C=24 everywhere.
- DATA_WIDTH=8, K=1, A=-128, B=-128: C=16384 (0x00004000). With ACC_WIDTH=14, C wraps to 0.
- k_len=0 with acc_en=0: 16 writes of 0 at c_base..c_base+60, then done. No reads are issued.
- Assert resetn low during LOADB, then release: all outputs go to reset values immediately. A new start gives correct C. start pulses during WRITE are ignored.
- RD_LAT=3, N=2, K=3 with random int8 data against a reference model: C matches. Timing is 3·8+4 = 28 cycles to done.

Source files
------------

// File: rtl/mm_tile_controller.sv
// mm_tile_controller
//   N x N integer matrix-multiply tile engine: C = A*B (+ previous C) over a
//   runtime inner dimension K. Operands come from a single-port BRAM, products
//   accumulate in an internal N x N MAC array, and C is written back to the
//   same BRAM, row-major.
//
// Ports
//   clk, resetn        : clock, asynchronous active-low reset
//   start              : launch, sampled only in IDLE
//   k_len              : inner dimension K, sampled with start
//   acc_en             : 1 keeps accumulators from the previous run, 0 clears them
//   a_base/b_base/c_base : byte base addresses, sampled with start
//   bram_addr          : registered byte address
//   bram_rddata        : read data, valid RD_LAT cycles after the address
//   bram_wrdata        : write data (sign-extended accumulator)
//   bram_we            : byte write enables, all-ones only in WRITE
//   busy               : high in every state except IDLE
//   done               : high for DONE_STATE_CYCLE cycles after the last write
//
// Handshake: start is a level sampled on the rising edge while IDLE; once
// accepted, every other start is ignored until the engine is back in IDLE.
// The current FSM state is visible on the internal enum signal state_q.
module mm_tile_controller #(
    parameter int LINE_SIZE        = 8,
    parameter int DATA_WIDTH       = 8,
    parameter int ACC_WIDTH        = 32,
    parameter int BRAM_ADDR_WIDTH  = 15,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int K_WIDTH          = 8,
    parameter int RD_LAT           = 1,
    parameter int DONE_STATE_CYCLE = 5
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         acc_en,
    input  logic [BRAM_ADDR_WIDTH-1:0]   a_base,
    input  logic [BRAM_ADDR_WIDTH-1:0]   b_base,
    input  logic [BRAM_ADDR_WIDTH-1:0]   c_base,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]   bram_rddata,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_we,
    output logic                         busy,
    output logic                         done
);

    localparam int AW    = BRAM_ADDR_WIDTH;
    localparam int BDW   = BRAM_DATA_WIDTH;
    localparam int BYTES = BRAM_DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(LINE_SIZE);
    localparam int DC_W  = $clog2(DONE_STATE_CYCLE + 1);
    // Product width wide enough for the full signed product and the accumulator.
    localparam int PW    = (ACC_WIDTH > 2 * DATA_WIDTH) ? ACC_WIDTH : 2 * DATA_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LINE_SIZE - 1);
    localparam logic [1:0]       LAST_DRAIN = 2'(RD_LAT - 1);
    localparam logic [DC_W-1:0]  LAST_DONE  = DC_W'(DONE_STATE_CYCLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADA, S_LOADB, S_DRAIN, S_MAC, S_WRITE, S_DONE
    } state_t;

    // Each issued read carries a tag down a RD_LAT-deep shift register so the
    // returning word lands in the right operand buffer slot.
    typedef struct packed {
        logic             valid;
        logic             is_b;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t                 state_q, state_d;
    logic [K_WIDTH-1:0]     k_len_q, k_len_d, k_q, k_d, k_inc;
    logic [AW-1:0]          a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [BDW-1:0]         wrdata_q, wrdata_d;
    logic                   we_q, we_d;
    logic [IDX_W-1:0]       row_q, row_d, col_q, col_d;
    logic [1:0]             dcnt_q, dcnt_d;
    logic [DC_W-1:0]        dncnt_q, dncnt_d;
    tag_t                   tag_q [RD_LAT];
    tag_t                   tag_d [RD_LAT];
    logic [DATA_WIDTH-1:0]  abuf_q [LINE_SIZE];
    logic [DATA_WIDTH-1:0]  abuf_d [LINE_SIZE];
    logic [DATA_WIDTH-1:0]  bbuf_q [LINE_SIZE];
    logic [DATA_WIDTH-1:0]  bbuf_d [LINE_SIZE];
    logic [ACC_WIDTH-1:0]   acc_q  [LINE_SIZE][LINE_SIZE];
    logic [ACC_WIDTH-1:0]   acc_d  [LINE_SIZE][LINE_SIZE];
    logic [ACC_WIDTH-1:0]   acc_term [LINE_SIZE][LINE_SIZE];

    assign k_inc = k_q + K_WIDTH'(1);

    // Signed product truncated to the accumulator width (wraps, no saturation).
    for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < LINE_SIZE; gj++) begin : g_col
            assign acc_term[gi][gj] =
                ACC_WIDTH'(PW'($signed(abuf_q[gi])) * PW'($signed(bbuf_q[gj])));
        end
    end

    if (BDW > DATA_WIDTH) begin : g_rd_hi
        logic unused_rd_hi;
        assign unused_rd_hi = ^bram_rddata[BDW-1:DATA_WIDTH];
    end

    function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                                input logic [31:0]   idx);
        return base + AW'(idx * 32'(BYTES));
    endfunction

    function automatic logic [BDW-1:0] sext_acc(input logic [ACC_WIDTH-1:0] a);
        return BDW'($signed(a));
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (k_len == '0) ? S_WRITE : S_LOADA;
            S_LOADA: if (row_q == LAST_IDX) state_d = S_LOADB;
            S_LOADB: if (col_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: if (dcnt_q == LAST_DRAIN) state_d = S_MAC;
            S_MAC:   state_d = (k_inc < k_len_q) ? S_LOADA : S_WRITE;
            S_WRITE: if (row_q == LAST_IDX && col_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  if (dncnt_q == LAST_DONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    // Address, write data and write enable are registered: each is computed
    // here for the cycle the FSM is about to enter.
    always_comb begin
        k_len_d  = k_len_q;
        k_d      = k_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        we_d     = 1'b0;
        row_d    = row_q;
        col_d    = col_q;
        dcnt_d   = dcnt_q;
        dncnt_d  = dncnt_q;
        abuf_d   = abuf_q;
        bbuf_d   = bbuf_q;
        acc_d    = acc_q;

        tag_d[0] = '0;
        for (int t = 1; t < RD_LAT; t++) tag_d[t] = tag_q[t-1];

        if (tag_q[RD_LAT-1].valid) begin
            if (tag_q[RD_LAT-1].is_b) bbuf_d[tag_q[RD_LAT-1].idx] = bram_rddata[DATA_WIDTH-1:0];
            else                      abuf_d[tag_q[RD_LAT-1].idx] = bram_rddata[DATA_WIDTH-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_len_d  = k_len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    c_base_d = c_base;
                    k_d      = '0;
                    row_d    = '0;
                    col_d    = '0;
                    if (!acc_en) begin
                        for (int i = 0; i < LINE_SIZE; i++)
                            for (int j = 0; j < LINE_SIZE; j++)
                                acc_d[i][j] = '0;
                    end
                    if (k_len == '0) begin
                        addr_d   = c_base;
                        wrdata_d = sext_acc(acc_d[0][0]);
                        we_d     = 1'b1;
                    end else begin
                        addr_d   = a_base;
                    end
                end
            end
            S_LOADA: begin
                tag_d[0] = '{valid: 1'b1, is_b: 1'b0, idx: row_q};
                if (row_q == LAST_IDX) begin
                    col_d  = '0;
                    addr_d = elem_addr(b_base_q, 32'(k_q) * 32'(LINE_SIZE));
                end else begin
                    row_d  = row_q + 1'b1;
                    addr_d = elem_addr(a_base_q, (32'(row_q) + 32'd1) * 32'(k_len_q) + 32'(k_q));
                end
            end
            S_LOADB: begin
                tag_d[0] = '{valid: 1'b1, is_b: 1'b1, idx: col_q};
                if (col_q == LAST_IDX) begin
                    dcnt_d = '0;
                end else begin
                    col_d  = col_q + 1'b1;
                    addr_d = elem_addr(b_base_q, 32'(k_q) * 32'(LINE_SIZE) + 32'(col_q) + 32'd1);
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + 2'd1;
            end
            S_MAC: begin
                for (int i = 0; i < LINE_SIZE; i++)
                    for (int j = 0; j < LINE_SIZE; j++)
                        acc_d[i][j] = acc_q[i][j] + acc_term[i][j];
                k_d   = k_inc;
                row_d = '0;
                col_d = '0;
                if (k_inc < k_len_q) begin
                    addr_d = elem_addr(a_base_q, 32'(k_inc));
                end else begin
                    // First write uses the sums that include this MAC step.
                    addr_d   = c_base_q;
                    wrdata_d = sext_acc(acc_d[0][0]);
                    we_d     = 1'b1;
                end
            end
            S_WRITE: begin
                if (row_q == LAST_IDX && col_q == LAST_IDX) begin
                    dncnt_d = '0;
                end else begin
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    addr_d   = elem_addr(c_base_q, 32'(row_d) * 32'(LINE_SIZE) + 32'(col_d));
                    wrdata_d = sext_acc(acc_q[row_d][col_d]);
                    we_d     = 1'b1;
                end
            end
            S_DONE: begin
                dncnt_d = dncnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k_len_q  <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            we_q     <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            dcnt_q   <= '0;
            dncnt_q  <= '0;
            for (int t = 0; t < RD_LAT; t++) tag_q[t] <= '0;
            for (int i = 0; i < LINE_SIZE; i++) begin
                abuf_q[i] <= '0;
                bbuf_q[i] <= '0;
                for (int j = 0; j < LINE_SIZE; j++) acc_q[i][j] <= '0;
            end
        end else begin
            k_len_q  <= k_len_d;
            k_q      <= k_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            we_q     <= we_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dcnt_q   <= dcnt_d;
            dncnt_q  <= dncnt_d;
            tag_q    <= tag_d;
            abuf_q   <= abuf_d;
            bbuf_q   <= bbuf_d;
            acc_q    <= acc_d;
        end
    end

    assign bram_addr   = addr_q;
    assign bram_wrdata = wrdata_q;
    assign bram_we     = {BYTES{we_q}};
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule
